niosii_cpu_mul_combine: RTL and testbench

NIOSII_CPU_MUL_COMBINE -- requirements
Module: niosii_cpu_mul_combine

---
 rtl/niosii_cpu_mul_combine_if.sv | 30 +++
 rtl/niosii_cpu_mul_combine.sv | 100 ++++++++++
 tb/tb_niosii_cpu_mul_combine.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/niosii_cpu_mul_combine_if.sv
// Handshake and data bundle for the multiplier partial-product combiner.
// slave is the combiner's view; master is the producer/consumer view.
interface niosii_cpu_mul_combine_if #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      p1;
  logic [31:0]      p2;
  logic [31:0]      p3;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, p1, p2, p3, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy, op_count
  );

  modport master (
    output in_valid, p1, p2, p3, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy, op_count
  );
endinterface

// File: rtl/niosii_cpu_mul_combine.sv
// Two-stage combiner producing the low 32 bits of a 32x32 product from three
// 16x16 partial products. Optional completion counter: MUL_COMBINE_STATS_EN.
module niosii_cpu_mul_combine #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  niosii_cpu_mul_combine_if.slave  bus
);

  logic             a_valid;
  logic [31:0]      a_p1;
  logic [15:0]      a_mid;
  logic [TAG_W-1:0] a_tag;

  logic             b_valid;
  logic [31:0]      b_result;
  logic [TAG_W-1:0] b_tag;

  logic             out_fire;
  logic             b_free;
  logic             a_advance;
  logic             in_ready_int;
  logic             in_fire;
  logic [15:0]      mid_next;
  logic [31:0]      result_next;

  // Upper halves of the cross products only affect bits above 31.
  logic unused_hi;
  assign unused_hi = ^{bus.p2[31:16], bus.p3[31:16]};

  always_comb begin
    out_fire     = b_valid && bus.out_ready;
    b_free       = !b_valid || bus.out_ready;
    a_advance    = a_valid && b_free;
    in_ready_int = !a_valid || a_advance;
    in_fire      = bus.in_valid && in_ready_int;
    mid_next     = bus.p2[15:0] + bus.p3[15:0];
    result_next  = a_p1 + {a_mid, 16'h0000};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_p1    <= '0;
      a_mid   <= '0;
      a_tag   <= '0;
    end else if (bus.flush) begin
      a_valid <= 1'b0;
    end else if (in_fire) begin
      a_valid <= 1'b1;
      a_p1    <= bus.p1;
      a_mid   <= mid_next;
      a_tag   <= bus.in_tag;
    end else if (a_advance) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid  <= 1'b0;
      b_result <= '0;
      b_tag    <= '0;
    end else if (bus.flush) begin
      b_valid <= 1'b0;
    end else if (a_advance) begin
      b_valid  <= 1'b1;
      b_result <= result_next;
      b_tag    <= a_tag;
    end else if (out_fire) begin
      b_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = b_valid;
  assign bus.out_result = b_result;
  assign bus.out_tag    = b_tag;
  assign bus.busy       = a_valid || b_valid;

`ifdef MUL_COMBINE_STATS_EN
  logic [CNT_W-1:0] op_cnt;

  // A transfer coinciding with flush is killed, so it is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_cnt <= '0;
    end else if (out_fire && !bus.flush && !(&op_cnt)) begin
      op_cnt <= op_cnt + CNT_W'(1);
    end
  end

  assign bus.op_count = op_cnt;
`else
  assign bus.op_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_niosii_cpu_mul_combine.sv
// Self-checking bench: directed scenarios plus a randomized scoreboard run
// whose reference multiplies full 32-bit sources.
module tb_niosii_cpu_mul_combine;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MUL_COMBINE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int unsigned      acc;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned edge_cnt = 0;

  niosii_cpu_mul_combine_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  niosii_cpu_mul_combine #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'h0, a} * {32'h0, b};
    return full[31:0];
  endfunction

  function automatic int exp_count(input int n);
    if (!STATS_EN) return 0;
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // Drives the three partial products a multiplier cell would produce.
  task automatic set_ops(input logic [31:0] s1, input logic [31:0] s2, input logic [TAG_W-1:0] tag);
    bus.p1     = {16'h0, s1[15:0]}  * {16'h0, s2[15:0]};
    bus.p2     = {16'h0, s1[15:0]}  * {16'h0, s2[31:16]};
    bus.p3     = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
    bus.in_tag = tag;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_result !== 32'h0 || bus.out_tag !== '0 || bus.op_count !== '0) begin
      n_fail++; $display("FAIL reset_data: result=%h tag=%h cnt=%0d want 0", bus.out_result, bus.out_tag, bus.op_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.p1 = 32'h0000000F; bus.p2 = 32'h0000000C; bus.p3 = 32'h0000000A; bus.in_tag = 5'd3;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_first_accept: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk); @(negedge clk);
    idle(); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_stage_a: out_valid=%b busy=%b want 0 1", bus.out_valid, bus.busy);
    end
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0016000F || bus.out_tag !== 5'd3) begin
      n_fail++; $display("FAIL basic_result: valid=%b result=%h tag=%0d want 1 0016000f 3",
                         bus.out_valid, bus.out_result, bus.out_tag);
    end
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    set_ops(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9);
    @(posedge clk); @(negedge clk);
    idle();
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h00000001 || bus.out_tag !== 5'd9) begin
      n_fail++; $display("FAIL wrap_result: valid=%b result=%h tag=%0d want 1 00000001 9",
                         bus.out_valid, bus.out_result, bus.out_tag);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]      s1 [1:4];
    logic [31:0]      s2 [1:4];
    int               next_in = 1;
    int               next_out = 1;
    logic             stalled = 1'b0;
    logic [31:0]      prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    for (int i = 1; i <= 4; i++) begin
      s1[i] = $urandom; s2[i] = $urandom;
    end
    for (int cyc = 0; cyc < 20 && next_out <= 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 3);
      bus.flush     = 1'b0;
      bus.in_valid  = (next_in <= 4);
      if (next_in <= 4) set_ops(s1[next_in], s2[next_in], TAG_W'(next_in));
      #1;
      if (cyc == 2) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready);
        end
      end
      if (stalled) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== prev_res || bus.out_tag !== prev_tag) begin
          n_fail++; $display("FAIL bp_hold: valid=%b result=%h tag=%0d want 1 %h %0d",
                             bus.out_valid, bus.out_result, bus.out_tag, prev_res, prev_tag);
        end
      end
      if (bus.out_valid === 1'b1) begin
        n_checks++;
        if (bus.out_tag !== TAG_W'(next_out) || bus.out_result !== ref_mul(s1[next_out], s2[next_out])) begin
          n_fail++; $display("FAIL bp_order: tag=%0d result=%h want %0d %h", bus.out_tag, bus.out_result,
                             next_out, ref_mul(s1[next_out], s2[next_out]));
        end
      end
      stalled  = bus.out_valid && !bus.out_ready;
      prev_res = bus.out_result;
      prev_tag = bus.out_tag;
      if (bus.out_valid && bus.out_ready) next_out++;
      if (bus.in_valid && bus.in_ready) next_in++;
    end
    @(negedge clk);
    idle(); #1;
    n_checks++;
    if (next_out != 5 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_complete: outputs=%0d valid=%b busy=%b want 4 0 0",
                         next_out - 1, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b;
    reset_dut();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_ops($urandom, $urandom, 5'd10);
    @(posedge clk); @(negedge clk);
    set_ops($urandom, $urandom, 5'd11);
    @(posedge clk); @(negedge clk);
    set_ops($urandom, $urandom, 5'd12);
    #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_prefill: busy=%b valid=%b in_ready=%b want 1 1 0",
                         bus.busy, bus.out_valid, bus.in_ready);
    end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    idle(); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_count !== CNT_W'(0)) begin
      n_fail++; $display("FAIL flush_clear: valid=%b busy=%b cnt=%0d want 0 0 0",
                         bus.out_valid, bus.busy, bus.op_count);
    end
    a = $urandom; b = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b1;
    set_ops(a, b, 5'd13);
    @(posedge clk); @(negedge clk);
    idle();
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd13 || bus.out_result !== ref_mul(a, b)) begin
      n_fail++; $display("FAIL flush_next_op: valid=%b tag=%0d result=%h want 1 13 %h",
                         bus.out_valid, bus.out_tag, bus.out_result, ref_mul(a, b));
    end
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.op_count !== CNT_W'(exp_count(1))) begin
      n_fail++; $display("FAIL flush_count: got %0d want %0d", bus.op_count, exp_count(1));
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] a, b;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    set_ops($urandom, $urandom, 5'd20);
    @(posedge clk); @(negedge clk);
    idle();
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_loaded: valid=%b want 1", bus.out_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_result !== 32'h0 ||
        bus.out_tag !== '0 || bus.op_count !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: valid=%b busy=%b result=%h tag=%0d cnt=%0d in_ready=%b want 0 0 0 0 0 1",
                         bus.out_valid, bus.busy, bus.out_result, bus.out_tag, bus.op_count, bus.in_ready);
    end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    a = $urandom; b = $urandom;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    set_ops(a, b, 5'd21);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_accept: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk); @(negedge clk);
    idle(); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_latency: early valid=%b want 0", bus.out_valid);
    end
    @(posedge clk); @(negedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd21 || bus.out_result !== ref_mul(a, b)) begin
      n_fail++; $display("FAIL rstmid_result: valid=%b tag=%0d result=%h want 1 21 %h",
                         bus.out_valid, bus.out_tag, bus.out_result, ref_mul(a, b));
    end
  endtask

  task automatic test_counter();
    int issued = 0;
    int xfers = 0;
    reset_dut();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 15 && xfers < 5; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (bus.op_count !== CNT_W'(exp_count(xfers))) begin
        n_fail++; $display("FAIL cnt_step: after %0d transfers got %0d want %0d", xfers, bus.op_count, exp_count(xfers));
      end
      bus.in_valid = (issued < 5);
      set_ops($urandom, $urandom, TAG_W'(issued));
      #1;
      if (bus.out_valid && bus.out_ready) xfers++;
      if (bus.in_valid && bus.in_ready) issued++;
    end
    @(negedge clk);
    idle(); #1;
    n_checks++;
    if (xfers != 5 || bus.op_count !== CNT_W'(exp_count(5))) begin
      n_fail++; $display("FAIL cnt_final: transfers=%0d cnt=%0d want 5 %0d", xfers, bus.op_count, exp_count(5));
    end
  endtask

  task automatic test_random();
    item_t       q[$];
    item_t       it;
    int          xfers = 0;
    int          n;
    logic        exp_ov, exp_ir;
    logic [31:0] a, b;
    reset_dut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_ops(a, b, TAG_W'($urandom));
      #1;
      n = q.size();
      exp_ir = (n < 2) || bus.out_ready;
      exp_ov = (n > 0) && (edge_cnt >= q[0].acc + 1);
      n_checks++;
      if (bus.in_ready !== exp_ir || bus.busy !== (n > 0) || bus.out_valid !== exp_ov) begin
        n_fail++; $display("FAIL rnd_flags: cyc=%0d in_ready=%b busy=%b valid=%b want %b %b %b",
                           cyc, bus.in_ready, bus.busy, bus.out_valid, exp_ir, (n > 0), exp_ov);
      end
      if (exp_ov) begin
        n_checks++;
        if (bus.out_result !== q[0].res || bus.out_tag !== q[0].tag) begin
          n_fail++; $display("FAIL rnd_data: cyc=%0d result=%h tag=%0d want %h %0d",
                             cyc, bus.out_result, bus.out_tag, q[0].res, q[0].tag);
        end
      end
      n_checks++;
      if (bus.op_count !== CNT_W'(exp_count(xfers))) begin
        n_fail++; $display("FAIL rnd_count: cyc=%0d got %0d want %0d", cyc, bus.op_count, exp_count(xfers));
      end
      if (bus.flush) begin
        q.delete();
      end else begin
        if (exp_ov && bus.out_ready) begin
          void'(q.pop_front());
          xfers++;
        end
        if (bus.in_valid && exp_ir) begin
          it.res = ref_mul(a, b);
          it.tag = bus.in_tag;
          it.acc = edge_cnt + 1;
          q.push_back(it);
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.p1 = '0; bus.p2 = '0; bus.p3 = '0; bus.in_tag = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_counter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
